// File: rtl/pll_clk_sequencer.sv
// rtl/pll_clk_sequencer.sv - PLL power-up and lock supervisor
// Sequences PLL reset/power-down, qualifies lock with timeout and retry, then releases the counters.
module pll_clk_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 256,
  parameter int RETRY_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwrdwn_req_i,
  input  logic       locked_i,
  output logic       pll_rst_o,
  output logic       pll_pwrdwn_o,
  output logic       cnt_rst_o,
  output logic       cnt_en_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int RW      = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_PWRDN     = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_retry;
  logic [RW-1:0]   w_retry_next;
  logic [RW-1:0]   w_retry_inc;
  logic            r_lock_meta;
  logic            r_lock_s;
  logic [7:0]      r_loss_cnt;
  logic            w_loss_inc;
  logic            r_pll_rst;
  logic            r_pll_pwrdwn;
  logic            r_cnt_rst;
  logic            r_cnt_en;
  logic            r_ready;
  logic            w_rst_done;
  logic            w_timeout;
  logic            w_stable_done;

  assign w_rst_done    = (r_timer == TW'(RST_CYCLES - 1));
  assign w_timeout     = (r_timer == TW'(LOCK_TIMEOUT - 1));
  assign w_stable_done = (r_timer == TW'(LOCK_STABLE - 1));
  assign w_retry_inc   = r_retry + RW'(1);

  // Priority: power-down request, then lock status, then timer expiry.
  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_loss_inc   = 1'b0;
    if (pwrdwn_req_i) begin
      w_next = S_PWRDN;
    end else begin
      case (r_state)
        S_PWRDN: begin
          w_next       = S_RESET;
          w_retry_next = '0;
        end
        S_RESET: begin
          if (w_rst_done) w_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_next = S_STABLE;
          end else if (w_timeout) begin
            w_retry_next = w_retry_inc;
            w_next       = (w_retry_inc == RW'(RETRY_MAX)) ? S_FAULT : S_RESET;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_next = S_WAIT_LOCK;
          end else if (w_stable_done) begin
            w_next       = S_RUN;
            w_retry_next = '0;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_next     = S_RESET;
            w_loss_inc = 1'b1;
          end
        end
        S_FAULT: w_next = S_FAULT;
        default: w_next = S_RESET;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RESET;
      r_timer      <= '0;
      r_retry      <= '0;
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_loss_cnt   <= 8'd0;
      r_pll_rst    <= 1'b1;
      r_pll_pwrdwn <= 1'b0;
      r_cnt_rst    <= 1'b1;
      r_cnt_en     <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_lock_meta <= locked_i;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_next;
      r_retry     <= w_retry_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_state inside {S_RESET, S_WAIT_LOCK, S_STABLE}) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
      r_pll_rst    <= (w_next == S_PWRDN) || (w_next == S_RESET) || (w_next == S_FAULT);
      r_pll_pwrdwn <= (w_next == S_PWRDN);
      r_cnt_rst    <= (w_next != S_RUN);
      r_cnt_en     <= (w_next == S_RUN);
      r_ready      <= (w_next == S_RUN);
    end
  end

  assign pll_rst_o       = r_pll_rst;
  assign pll_pwrdwn_o    = r_pll_pwrdwn;
  assign cnt_rst_o       = r_cnt_rst;
  assign cnt_en_o        = r_cnt_en;
  assign ready_o         = r_ready;
  assign state_o         = r_state;
  assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// tb/tb_pll_clk_sequencer.sv - self-checking bench for pll_clk_sequencer
// Reference model tracks state by dwell time and a two-deep lock history.
module tb_pll_clk_sequencer;
  localparam int RST_C = 4;
  localparam int TO    = 32;
  localparam int STB   = 8;
  localparam int RMAX  = 2;
  localparam logic [15:0] RESET_OUTS = 16'hA100;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwrdwn_req_i;
  logic       locked_i;
  logic       pll_rst_o;
  logic       pll_pwrdwn_o;
  logic       cnt_rst_o;
  logic       cnt_en_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  pll_clk_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO), .LOCK_STABLE(STB), .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst), .pwrdwn_req_i(pwrdwn_req_i), .locked_i(locked_i),
    .pll_rst_o(pll_rst_o), .pll_pwrdwn_o(pll_pwrdwn_o), .cnt_rst_o(cnt_rst_o),
    .cnt_en_o(cnt_en_o), .ready_o(ready_o), .state_o(state_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_state, m_dwell, m_retry, m_loss;
  bit m_meta, m_s;

  logic [15:0] act;
  assign act = {pll_rst_o, pll_pwrdwn_o, cnt_rst_o, cnt_en_o, ready_o, state_o, lock_loss_cnt_o};

  function automatic logic [15:0] exp_outs();
    logic [15:0] e;
    e[15]   = (m_state == 0) || (m_state == 1) || (m_state == 5);
    e[14]   = (m_state == 0);
    e[13]   = (m_state != 4);
    e[12]   = (m_state == 4);
    e[11]   = (m_state == 4);
    e[10:8] = 3'(m_state);
    e[7:0]  = 8'(m_loss);
    return e;
  endfunction

  task automatic model_reset();
    m_state = 1; m_dwell = 0; m_retry = 0; m_loss = 0; m_meta = 0; m_s = 0;
  endtask

  // One clock edge of the supervisor rules: dwell = edges already spent in the state.
  task automatic model_edge(input bit lk, input bit pd);
    int ns;
    ns = m_state;
    if (pd) ns = 0;
    else begin
      case (m_state)
        0: begin ns = 1; m_retry = 0; end
        1: if (m_dwell + 1 == RST_C) ns = 2;
        2: if (m_s) ns = 3;
           else if (m_dwell + 1 == TO) begin
             m_retry = m_retry + 1;
             ns = (m_retry == RMAX) ? 5 : 1;
           end
        3: if (!m_s) ns = 2;
           else if (m_dwell + 1 == STB) begin ns = 4; m_retry = 0; end
        4: if (!m_s) begin ns = 1; if (m_loss < 255) m_loss = m_loss + 1; end
        default: ns = m_state;
      endcase
    end
    m_dwell = (ns != m_state) ? 0 : m_dwell + 1;
    m_state = ns;
    m_s = m_meta;
    m_meta = lk;
  endtask

  task automatic tick(input bit lk, input bit pd);
    locked_i = lk;
    pwrdwn_req_i = pd;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(lk, pd);
    @(negedge clk);
  endtask

  task automatic apply_reset(input bit lk);
    rst = 1'b1;
    model_reset();
    tick(lk, 1'b0);
    tick(lk, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_i = 1'b1; pwrdwn_req_i = 1'b0;
    model_reset();
    tick(1, 0);
    tick(1, 0);
    checks++;
    if (act !== RESET_OUTS) begin
      errors++; $display("FAIL reset_values act=%h exp=%h", act, RESET_OUTS);
    end
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    int seq[$];
    apply_reset(1);
    seq.push_back(1);
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0);
      if (int'(state_o) != seq[seq.size()-1]) seq.push_back(int'(state_o));
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL bringup_model tick=%0d act=%h exp=%h", i, act, exp_outs());
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (pll_rst_o !== (i == 3)) begin
          errors++; $display("FAIL bringup_pll_rst tick=%0d act=%b exp=%b", i, pll_rst_o, (i == 3));
        end
      end
      if (i == 12 || i == 13) begin
        checks++;
        if ({ready_o, cnt_en_o, cnt_rst_o} !== ((i == 13) ? 3'b110 : 3'b001)) begin
          errors++; $display("FAIL bringup_ready tick=%0d act=%b", i, {ready_o, cnt_en_o, cnt_rst_o});
        end
      end
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3 || seq[3] != 4) begin
      errors++; $display("FAIL bringup_sequence act_len=%0d exp=1,2,3,4", seq.size());
    end
  endtask

  task automatic test_no_lock();
    apply_reset(0);
    for (int i = 1; i <= 90; i++) begin
      tick(0, 0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL nolock_model tick=%0d act=%h exp=%h", i, act, exp_outs());
      end
      if (i == 36 || i == 71 || i == 72) begin
        checks++;
        if (int'(state_o) != ((i == 36) ? 1 : (i == 71) ? 2 : 5)) begin
          errors++; $display("FAIL nolock_state tick=%0d act=%0d", i, state_o);
        end
      end
    end
    checks++;
    if (state_o !== 3'd5 || pll_rst_o !== 1'b1 || cnt_en_o !== 1'b0) begin
      errors++; $display("FAIL nolock_fault act=%0d/%b/%b exp=5/1/0", state_o, pll_rst_o, cnt_en_o);
    end
  endtask

  task automatic test_glitch();
    apply_reset(1);
    for (int i = 1; i <= 24; i++) begin
      tick((i == 9) ? 1'b0 : 1'b1, 0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL glitch_model tick=%0d act=%h exp=%h", i, act, exp_outs());
      end
      if (i == 11 || i == 12 || i == 19 || i == 20) begin
        checks++;
        if (int'(state_o) != ((i == 11) ? 2 : (i == 20) ? 4 : 3)) begin
          errors++; $display("FAIL glitch_state tick=%0d act=%0d", i, state_o);
        end
      end
    end
  endtask

  task automatic lose_lock(input string name, input bit check_latency);
    tick(0, 0);
    for (int j = 1; j <= 19; j++) begin
      if (check_latency && j == 1) begin
        checks++;
        if (ready_o !== 1'b1) begin
          errors++; $display("FAIL %s_latency_early act=%b exp=1", name, ready_o);
        end
      end
      tick(1, 0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL %s_model step=%0d act=%h exp=%h", name, j, act, exp_outs());
      end
      if (check_latency && j <= 2) begin
        checks++;
        if ({ready_o, cnt_en_o, cnt_rst_o} !== ((j == 1) ? 3'b110 : 3'b001)) begin
          errors++; $display("FAIL %s_latency step=%0d act=%b", name, j, {ready_o, cnt_en_o, cnt_rst_o});
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    apply_reset(1);
    for (int i = 0; i < 13; i++) tick(1, 0);
    for (int k = 0; k < 3; k++) lose_lock("lockloss", k == 0);
    checks++;
    if (lock_loss_cnt_o !== 8'd3 || state_o !== 3'd4) begin
      errors++; $display("FAIL lockloss_count act=%0d state=%0d exp=3 state=4", lock_loss_cnt_o, state_o);
    end
  endtask

  task automatic test_pwrdn();
    tick(1, 1);
    checks++;
    if ({state_o, pll_pwrdwn_o, pll_rst_o, ready_o} !== 6'b000110) begin
      errors++; $display("FAIL pwrdn_entry act=%b exp=000110", {state_o, pll_pwrdwn_o, pll_rst_o, ready_o});
    end
    for (int i = 0; i < 3; i++) tick(1, 1);
    for (int i = 1; i <= 14; i++) begin
      tick(1, 0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL pwrdn_model tick=%0d act=%h exp=%h", i, act, exp_outs());
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (pll_rst_o !== (i == 4)) begin
          errors++; $display("FAIL pwrdn_pll_rst tick=%0d act=%b", i, pll_rst_o);
        end
      end
    end
    checks++;
    if (ready_o !== 1'b1 || lock_loss_cnt_o !== 8'd3) begin
      errors++; $display("FAIL pwrdn_resume ready=%b cnt=%0d exp=1/3", ready_o, lock_loss_cnt_o);
    end
    for (int i = 0; i < 90; i++) tick(0, 0);
    checks++;
    if (state_o !== 3'd5) begin
      errors++; $display("FAIL pwrdn_to_fault act=%0d exp=5", state_o);
    end
    tick(1, 1);
    for (int i = 0; i < 14; i++) tick(1, 0);
    checks++;
    if (act !== exp_outs() || state_o !== 3'd4) begin
      errors++; $display("FAIL fault_recover act=%h exp=%h", act, exp_outs());
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) lose_lock("saturate", 0);
    checks++;
    if (lock_loss_cnt_o !== 8'd255) begin
      errors++; $display("FAIL saturate_count act=%0d exp=255", lock_loss_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1);
    for (int i = 0; i < 8; i++) tick(1, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act !== RESET_OUTS) begin
      errors++; $display("FAIL async_stable act=%h exp=%h", act, RESET_OUTS);
    end
    model_reset();
    tick(1, 0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) tick(1, 0);
    lose_lock("async_prep", 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act !== RESET_OUTS) begin
      errors++; $display("FAIL async_run act=%h exp=%h", act, RESET_OUTS);
    end
    model_reset();
    tick(1, 0);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit lk;
    bit pd;
    int len;
    apply_reset(1);
    for (int s = 0; s < 200; s++) begin
      pd = ($urandom_range(0, 9) == 0);
      lk = $urandom_range(0, 2) != 0;
      if (pd) len = $urandom_range(1, 5);
      else if (!lk) len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 80) : $urandom_range(1, 3);
      else len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        tick(lk, pd);
        checks++;
        if (act !== exp_outs()) begin
          errors++; $display("FAIL random seg=%0d act=%h exp=%h", s, act, exp_outs());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; locked_i = 1'b0; pwrdwn_req_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_bringup();
    test_no_lock();
    test_glitch();
    test_lock_loss();
    test_pwrdn();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_clk_sequencer.md
# pll_clk_sequencer

Power-up and lock supervisor for the board PLL that generates the counter clocks. Drives the PLL reset and power-down controls, waits for a stable lock with timeout and bounded retry, and only then releases the counter reset and enable. It re-sequences automatically on lock loss and reports status for the LED and seven-segment display path. Runs in the 100 MHz board clock domain.

## Interface
- RST_CYCLES, 16: PLL reset pulse length in clk cycles (≥2).
- LOCK_TIMEOUT, 100000: max cycles in WAIT_LOCK before a retry.
- LOCK_STABLE, 256: cycles the synchronised lock must stay high before RUN.
- RETRY_MAX, 3: consecutive failed lock attempts before FAULT (≥1).
- clk  in  1  100 MHz board clock.
- rst  in  1  asynchronous, active-high reset.
- pwrdwn_req_i  in  1  synchronous power-down request; level-sensitive.
- locked_i  in  1  PLL LOCKED; asynchronous to clk.
- pll_rst_o  out  1  PLL RST.
- pll_pwrdwn_o  out  1  PLL PWRDWN.
- cnt_rst_o  out  1  counter reset, active-high.
- cnt_en_o  out  1  counter enable.
- ready_o  out  1  high only in RUN.
- state_o  out  3  current state code.
- lock_loss_cnt_o  out  8  saturating count of RUN→lock-loss events.

## Operation
- locked_i passes through a 2-FF synchroniser, giving locked_s. Only locked_s is used.
- States and codes: PWRDN=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- One shared timer. Its width is clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and LOCK_STABLE. It clears on every state change.
- All outputs are registered Moore decodes of the state register.
  - pll_rst_o=1 in PWRDN, RESET and FAULT.
  - pll_pwrdwn_o=1 in PWRDN only.
  - cnt_rst_o=0 and cnt_en_o=1 only in RUN.
- RESET: lasts exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1, increment retry.
  - If the new retry equals RETRY_MAX, go to FAULT; otherwise go to RESET.
- STABLE:
  - If locked_s=0 at any cycle, go to WAIT_LOCK. The timer restarts and retry is unchanged.
  - After LOCK_STABLE consecutive cycles with locked_s=1, go to RUN and clear retry.
- RUN: if locked_s=0, increment lock_loss_cnt_o (saturates at 255) and go to RESET.
- FAULT: terminal. Exit only via rst or a pwrdwn_req_i assertion.
- pwrdwn_req_i has the highest priority. When it is 1 in any state, the next state is PWRDN.
  - PWRDN holds while the request stays high.
  - On deassert, go to RESET with retry cleared. lock_loss_cnt_o is kept.
- Simultaneous events, in priority order: pwrdwn_req_i first, then lock loss, then timer expiry.
  - WAIT_LOCK: locked_s=1 in the timeout cycle means go to STABLE.
  - STABLE: lock drop in the final stable cycle means go to WAIT_LOCK.
- Reset values: state=RESET, pll_rst_o=1, pll_pwrdwn_o=0, cnt_rst_o=1, cnt_en_o=0, ready_o=0, state_o=1, lock_loss_cnt_o=0, retry=0, timer=0, synchroniser=0.
- rst asserted mid-operation forces the reset values immediately, including in RUN and FAULT.

## Timing
- Synchroniser latency: locked_i sampled high at edge N gives locked_s=1 after edge N+1, and state=STABLE after edge N+2.
- Lock loss in RUN reaches the outputs 3 edges after locked_i falls (cnt_en_o=0, cnt_rst_o=1, ready_o=0).
- After rst deasserts, pll_rst_o stays high for exactly RST_CYCLES rising edges.
- Minimum rst-release to ready_o=1 with locked_i constantly high: RST_CYCLES + 1 + LOCK_STABLE edges. The 2 synchroniser cycles overlap RESET.
- pwrdwn_req_i to pll_pwrdwn_o=1 takes 1 edge.
- The PWRDN exit plus the RESET pulse is RST_CYCLES+1 edges before pll_rst_o falls.
- Outputs change only on the rising edge of clk, except on asynchronous rst.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, RETRY_MAX=2.
- Bring-up: locked_i=1 from time 0, then release rst → pll_rst_o falls after edge 4; ready_o=1, cnt_en_o=1, cnt_rst_o=0 after edge 13; state_o sequence 1,2,3,4.
- Lock never arrives: locked_i=0 → two RESET/WAIT_LOCK cycles of 4+32 edges each, then state_o=5 permanently; pll_rst_o=1 and cnt_en_o=0 in FAULT.
- Glitchy lock: locked_i high 5 cycles, low 1, then high → STABLE→WAIT_LOCK→STABLE; RUN only 8 cycles after the final rise is synchronised; retry not incremented.
- Lock loss in RUN: drop locked_i three separate times → three RESET re-sequences, lock_loss_cnt_o=3; force 300 losses → saturates at 255.
- Power-down: assert pwrdwn_req_i in RUN → next edge state_o=0, pll_pwrdwn_o=1, pll_rst_o=1, ready_o=0; deassert → full bring-up, lock_loss_cnt_o unchanged; the same from FAULT recovers.
- Async reset mid-STABLE and mid-RUN: all outputs take their reset values with no clock edge; lock_loss_cnt_o=0.
